// File: rtl/tie170_pkg.sv
// Shared constants for the response path: bus width, response memory depth, opcodes, dump states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tie170_pkg;

  localparam int RESP_DATA_W = 8;
  localparam int RESP_DEPTH  = 64;
  localparam int RESP_ADDR_W = $clog2(RESP_DEPTH);

  // Opcode range emitted by the control unit into the opcode word of each entry.
  localparam logic [RESP_DATA_W-1:0] OPC_MIN = 8'h01;
  localparam logic [RESP_DATA_W-1:0] OPC_MAX = 8'hC0;

  // Dump FSM encoding.
  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_RD   = 2'd1,
    DUMP_OUT  = 2'd2,
    DUMP_FIN  = 2'd3
  } dump_state_t;

  // True when a recorded word lies in the opcode range.
  function automatic logic is_opcode(input logic [RESP_DATA_W-1:0] w);
    return (w >= OPC_MIN) && (w <= OPC_MAX);
  endfunction

endpackage

// File: rtl/response_ram.sv
// Simple dual-port response memory: one write port, one synchronous read port.
// Latency: write lands on the edge after wr_en; read data valid one cycle after rd_en.
// Backpressure: none; rd_data holds its value while rd_en is low.
module response_ram
  import tie170_pkg::*;
#(
  parameter int DATA_W = RESP_DATA_W,
  parameter int DEPTH  = RESP_DEPTH,
  parameter int ADDR_W = RESP_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array: never reset, contents only defined once written.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; reset so the dump output reads zero out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/response_recorder.sv
// Records (opcode, result) words from the control unit and streams them out on request.
// Latency: write on the edge after mem_load; dump yields one word per 2 cycles (RD then OUT).
// Backpressure: OUT holds data/addr until out_ready; clear or reset aborts without a handshake.
module response_recorder
  import tie170_pkg::*;
#(
  parameter int DATA_W = RESP_DATA_W,
  parameter int DEPTH  = RESP_DEPTH,
  parameter int ADDR_W = RESP_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              marr_load,
  input  logic              mem_load,
  input  logic              pr_inc,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              clear,
  input  logic              dump_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] PR_FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0]   pr;
  logic [ADDR_W-1:0] marr;
  logic              wr_en;

  dump_state_t       state, state_nxt;
  logic [ADDR_W:0]   len, len_nxt;
  logic [ADDR_W:0]   rd_ptr, rd_ptr_nxt, rd_ptr_inc;
  logic              rd_en;

  assign full      = (pr == PR_FULL);
  assign count     = pr;
  assign dump_busy = (state != DUMP_IDLE);
  assign out_addr  = rd_ptr[ADDR_W-1:0];
  assign rd_ptr_inc = rd_ptr + 1'b1;

  // A write while full is dropped (MARR would alias slot 0); clear suppresses recording too.
  assign wr_en = mem_load && !full && !clear;

  // Recording side: PR, MARR and the sticky overflow flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pr       <= '0;
      marr     <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      pr       <= '0;
      overflow <= 1'b0;
    end else begin
      if (marr_load)                   marr     <= pr[ADDR_W-1:0];
      if (pr_inc && !full)             pr       <= pr + 1'b1;
      if ((pr_inc || mem_load) && full) overflow <= 1'b1;
    end
  end

  response_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (marr),
    .wr_data (bus_in),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (out_data)
  );

  // Dump FSM state and snapshot registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= DUMP_IDLE;
      len    <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      len    <= len_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Dump FSM next state and outputs; clear overrides any transition.
  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    rd_ptr_nxt = rd_ptr;
    rd_en      = 1'b0;
    out_valid  = 1'b0;
    dump_done  = 1'b0;
    case (state)
      DUMP_IDLE: begin
        if (dump_start) begin
          len_nxt    = pr;
          rd_ptr_nxt = '0;
          state_nxt  = (pr == '0) ? DUMP_FIN : DUMP_RD;
        end
      end
      DUMP_RD: begin
        rd_en     = 1'b1;
        state_nxt = DUMP_OUT;
      end
      DUMP_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rd_ptr_nxt = rd_ptr_inc;
          state_nxt  = (rd_ptr_inc == len) ? DUMP_FIN : DUMP_RD;
        end
      end
      DUMP_FIN: begin
        dump_done = 1'b1;
        state_nxt = DUMP_IDLE;
      end
      default: state_nxt = DUMP_IDLE;
    endcase
    if (clear) state_nxt = DUMP_IDLE;
  end

endmodule

// File: tb/tb_response_recorder.sv
// Scoreboard bench for response_recorder: recorded words modelled in an array,
// dumps push expected (addr, data) into a queue, a monitor pops on each handshake.
module tb_response_recorder;
  import tie170_pkg::*;

  localparam int DW = 8;
  localparam int DP = 64;
  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          marr_load = 1'b0, mem_load = 1'b0, pr_inc = 1'b0;
  logic [DW-1:0] bus_in = '0;
  logic          clear = 1'b0, dump_start = 1'b0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          dump_busy, dump_done, full, overflow;
  logic [AW:0]   count;

  always #5 clock = ~clock;

  response_recorder dut (
    .clock(clock), .reset(reset), .marr_load(marr_load), .mem_load(mem_load),
    .pr_inc(pr_inc), .bus_in(bus_in), .clear(clear), .dump_start(dump_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .dump_busy(dump_busy), .dump_done(dump_done),
    .count(count), .full(full), .overflow(overflow)
  );

  typedef struct { int addr; int data; } word_t;
  word_t exp_q[$];

  int checks = 0, failures = 0;
  int done_seen = 0, done_exp = 0;
  int ready_mode = 2;   // 0: hold low, 1: random, 2: always high
  int model_mem [DP];
  int model_pr = 0;
  bit model_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer ready, updated just after each rising edge.
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: every accepted word is compared against the head of the scoreboard.
  always @(negedge clock) begin : mon
    word_t w;
    if (reset && dump_done) done_seen++;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word: got addr %0d data %0h expected none", out_addr, out_data);
      end else begin
        w = exp_q.pop_front();
        check("dump_addr", 32'(out_addr), w.addr);
        check("dump_data", 32'(out_data), w.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One control-unit record: marr_load, then mem_load+pr_inc with the word.
  task automatic record(input int d);
    marr_load = 1'b1;
    tick();
    marr_load = 1'b0;
    mem_load  = 1'b1;
    pr_inc    = 1'b1;
    bus_in    = d[DW-1:0];
    tick();
    mem_load  = 1'b0;
    pr_inc    = 1'b0;
    if (model_pr < DP) begin
      model_mem[model_pr] = d & 8'hFF;
      model_pr++;
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  task automatic issue_dump();
    word_t w;
    for (int i = 0; i < model_pr; i++) begin
      w.addr = i;
      w.data = model_mem[i];
      exp_q.push_back(w);
    end
    done_exp++;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_seen != done_exp && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({name, "_done"}, done_seen, done_exp);
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clock);
    while (!out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({name, "_valid_seen"}, out_valid, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_pr  = 0;
    model_ovf = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int bc, vs, n;
    repeat (3) @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_busy", dump_busy, 0);
    check("rst_done", dump_done, 0);
    check("rst_count", 32'(count), 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_addr", 32'(out_addr), 0);
    check("rst_data", 32'(out_data), 0);
    reset = 1'b1;
    tick();

    // Two hand-built entries and their dump.
    record(8'h10);
    record(8'h2A);
    @(negedge clock);
    check("t1_count", 32'(count), 2);
    ready_mode = 1;
    issue_dump();
    wait_done("t1");

    // Empty dump: brief busy, no words, one done pulse.
    do_clear();
    @(negedge clock);
    check("t2_count", 32'(count), 0);
    done_exp++;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    bc = 0;
    vs = 0;
    repeat (6) begin
      @(negedge clock);
      if (dump_busy) bc++;
      if (out_valid) vs++;
    end
    check("t2_busy_short", (bc >= 1 && bc <= 2), 1);
    check("t2_no_valid", vs, 0);
    check("t2_done", done_seen, done_exp);

    // Random contents, random consumer, one extra dump_start while busy.
    for (int r = 0; r < 3; r++) begin
      do_clear();
      n = $urandom_range(4, 12);
      for (int k = 0; k < n; k++) record($urandom_range(0, 255));
      ready_mode = 1;
      issue_dump();
      if (r == 1) begin
        tick();
        tick();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
      end
      wait_done("rand");
    end

    // Stall in OUT: word 0 held stable for five cycles.
    do_clear();
    for (int k = 0; k < 3; k++) record($urandom_range(0, 255));
    ready_mode = 0;
    issue_dump();
    wait_valid("t3");
    repeat (5) begin
      @(negedge clock);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_addr", 32'(out_addr), 0);
      check("t3_hold_data", 32'(out_data), model_mem[0]);
    end
    ready_mode = 2;
    wait_done("t3");

    // Fill past capacity: count saturates, overflow sticks, slot 0 untouched.
    do_clear();
    for (int k = 0; k < DP + 1; k++) record($urandom_range(0, 255));
    @(negedge clock);
    check("t4_count", 32'(count), DP);
    check("t4_full", full, 1);
    check("t4_ovf", overflow, model_ovf);
    ready_mode = 1;
    issue_dump();
    wait_done("t4");

    // Record during a dump: only the snapshot length is streamed.
    do_clear();
    for (int k = 0; k < 4; k++) record($urandom_range(0, 255));
    ready_mode = 1;
    issue_dump();
    for (int k = 0; k < 3; k++) record($urandom_range(0, 255));
    wait_done("t5");
    @(negedge clock);
    check("t5_count", 32'(count), 7);

    // Clear while stalled in OUT.
    do_clear();
    for (int k = 0; k < DP + 1; k++) record($urandom_range(0, 255));
    ready_mode = 0;
    issue_dump();
    wait_valid("t6c");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_pr  = 0;
    model_ovf = 1'b0;
    exp_q.delete();
    done_exp--;
    @(negedge clock);
    check("t6c_valid", out_valid, 0);
    check("t6c_busy", dump_busy, 0);
    check("t6c_count", 32'(count), 0);
    check("t6c_ovf", overflow, 0);
    repeat (5) @(negedge clock);
    check("t6c_no_done", done_seen, done_exp);

    // Async reset while stalled in OUT.
    record($urandom_range(0, 255));
    record($urandom_range(0, 255));
    ready_mode = 0;
    issue_dump();
    wait_valid("t6r");
    reset = 1'b0;
    #1;
    check("t6r_valid", out_valid, 0);
    check("t6r_busy", dump_busy, 0);
    check("t6r_count", 32'(count), 0);
    model_pr = 0;
    exp_q.delete();
    done_exp--;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("t6r_no_done", done_seen, done_exp);

    // Recording and dumping still work after the reset.
    record(8'h5C);
    record(8'hA3);
    ready_mode = 2;
    issue_dump();
    wait_done("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
